prog_updown_counter: RTL and testbench

Parametrised, programmable up/down counter for general-purpose timing and event counting. It generalises the fixed 32-bit down counter with:
- configurable width and reset value
- run-time direction control
- parallel load with a reload register
- four terminal-count modes, managed by a small IDLE/RUN/DONE control FSM
- a terminal-count pulse and status outputs

---
 rtl/prog_updown_counter.sv | 131 +++++++++++++
 tb/tb_prog_updown_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/prog_updown_counter.sv
// Programmable up/down counter with wrap/saturate/one-shot/auto-reload modes.
// Optional prescaler compiled in with `define PRESCALER_EN.
module prog_updown_counter #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_VAL  = {1'b0, {(WIDTH-1){1'b1}}},
   parameter int               PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic [1:0]            mode,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
`ifdef PRESCALER_EN
   input  logic [PRESCALE_W-1:0] presc,
`endif
   output logic [WIDTH-1:0]      out,
   output logic                  tc,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_rld;
   logic             r_tc;
   logic [WIDTH-1:0] w_out_nxt;
   logic [WIDTH-1:0] w_rld_nxt;
   logic             w_tc_nxt;
   logic [WIDTH-1:0] w_term;
   logic [WIDTH-1:0] w_inc;
   logic             w_at_t;
   logic             w_start_go;
   logic             w_run_en;
   logic             w_tick;
   logic             w_step;

   if (WIDTH < 2 || PRESCALE_W < 1) begin : g_bad_param
      $error("prog_updown_counter: WIDTH must be >= 2, PRESCALE_W >= 1");
   end

   assign w_term     = up_dn ? '1 : '0;
   assign w_at_t     = (r_out == w_term);
   assign w_inc      = up_dn ? r_out + WIDTH'(1) : r_out - WIDTH'(1);
   assign w_start_go = start && (r_state != S_RUN);
   assign w_run_en   = (r_state == S_RUN) && en && !load && !stop;
   assign w_step     = w_run_en && w_tick;

`ifdef PRESCALER_EN
   logic [PRESCALE_W-1:0] r_pcnt;
   logic                  w_clr_p;

   assign w_tick  = (r_pcnt == presc);
   assign w_clr_p = load || stop || w_start_go;

   always_ff @(posedge clk) begin
      if (rst || w_clr_p)
         r_pcnt <= '0;
      else if (w_run_en)
         r_pcnt <= w_tick ? '0 : r_pcnt + PRESCALE_W'(1);
   end
`else
   assign w_tick = 1'b1;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_out_nxt   = r_out;
      w_rld_nxt   = r_rld;
      w_tc_nxt    = 1'b0;
      if (load) begin
         w_out_nxt = load_val;
         w_rld_nxt = load_val;
         if (r_state == S_DONE)
            w_state_nxt = S_IDLE;
      end else if (stop) begin
         w_state_nxt = S_IDLE;
      end else if (w_start_go) begin
         w_state_nxt = S_RUN;
         if (r_state == S_DONE)
            w_out_nxt = r_rld;
      end else if (w_step) begin
         if (!w_at_t) begin
            w_out_nxt = w_inc;
            if (w_inc == w_term) begin
               w_tc_nxt = 1'b1;
               if (mode == 2'b10)
                  w_state_nxt = S_DONE;
            end
         end else begin
            // Already at T (e.g. started there): no tc is produced.
            unique case (mode)
               2'b00: w_out_nxt   = w_inc;
               2'b01: w_out_nxt   = r_out;
               2'b10: w_state_nxt = S_DONE;
               2'b11: w_out_nxt   = r_rld;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_out   <= RESET_VAL;
         r_rld   <= RESET_VAL;
         r_tc    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_out   <= w_out_nxt;
         r_rld   <= w_rld_nxt;
         r_tc    <= w_tc_nxt;
      end
   end

   assign out  = r_out;
   assign tc   = r_tc;
   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_prog_updown_counter.sv
// Directed self-checking bench for prog_updown_counter (32- and 8-bit instances).
// Prescaler checks are included when built with PRESCALER_EN.
module tb_prog_updown_counter;

   logic        clk = 1'b0;
   logic        rst, en, up_dn, start, stop, load;
   logic [1:0]  mode;
   logic [31:0] load_val32;
   logic [7:0]  load_val8;
   logic [7:0]  presc;
   logic [31:0] out32;
   logic [7:0]  out8;
   logic        tc32, busy32, done32;
   logic        tc8, busy8, done8;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   prog_updown_counter #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode),
      .start(start), .stop(stop), .load(load), .load_val(load_val32),
`ifdef PRESCALER_EN
      .presc(presc),
`endif
      .out(out32), .tc(tc32), .busy(busy32), .done(done32)
   );

   prog_updown_counter #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode),
      .start(start), .stop(stop), .load(load), .load_val(load_val8),
`ifdef PRESCALER_EN
      .presc(presc),
`endif
      .out(out8), .tc(tc8), .busy(busy8), .done(done8)
   );

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Stop with en low, load v, then start; leaves en=1, counter in RUN.
   task automatic arm(input logic [7:0] v);
      en = 0; stop = 1; cyc(); stop = 0;
      load = 1; load_val8 = v; load_val32 = 32'(v); cyc(); load = 0;
      start = 1; cyc(); start = 0;
      en = 1;
   endtask

   logic [7:0] e_wrap [5] = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE};
   logic       t_wrap [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [7:0] e_ar   [7] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h05, 8'h04};
   logic       t_ar   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      rst = 1; en = 0; up_dn = 0; start = 0; stop = 0; load = 0;
      mode = 2'b00; load_val32 = '0; load_val8 = '0;
      presc = 8'd0;
      cyc();
      chk("rst_out32", out32, 32'h7FFF_FFFF);
      chk("rst_out8", 32'(out8), 32'h7F);
      chk("rst_flags32", {29'd0, tc32, busy32, done32}, 32'd0);
      chk("rst_flags8", {29'd0, tc8, busy8, done8}, 32'd0);
      rst = 0;

      // 32-bit free-running down count, wrap mode
      en = 1; start = 1; cyc(); start = 0;
      chk("w32_busy", 32'(busy32), 32'd1);
      chk("w32_start_nostep", out32, 32'h7FFF_FFFF);
      cyc();
      chk("w32_s1", out32, 32'h7FFF_FFFE);
      cyc();
      chk("w32_s2", out32, 32'h7FFF_FFFD);
      chk("w32_tc", 32'(tc32), 32'd0);

      // 8-bit wrap down from 3
      mode = 2'b00; up_dn = 0;
      arm(8'h03);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("wrap_out", 32'(out8), 32'(e_wrap[i]));
         chk("wrap_tc", 32'(tc8), 32'(t_wrap[i]));
      end

      // saturate up from FD
      mode = 2'b01; up_dn = 1;
      arm(8'hFD);
      cyc();
      chk("sat_fe", 32'(out8), 32'hFE);
      chk("sat_fe_tc", 32'(tc8), 32'd0);
      cyc();
      chk("sat_ff", 32'(out8), 32'hFF);
      chk("sat_ff_tc", 32'(tc8), 32'd1);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("sat_hold", 32'(out8), 32'hFF);
         chk("sat_hold_tc", 32'(tc8), 32'd0);
      end

      // one-shot down from 2
      mode = 2'b10; up_dn = 0;
      arm(8'h02);
      cyc();
      chk("os_01", 32'(out8), 32'h01);
      chk("os_01_done", 32'(done8), 32'd0);
      cyc();
      chk("os_00", 32'(out8), 32'h00);
      chk("os_flags", {29'd0, tc8, busy8, done8}, 32'b101);
      cyc(); cyc();
      chk("os_hold", 32'(out8), 32'h00);
      chk("os_hold_flags", {29'd0, tc8, busy8, done8}, 32'b001);
      start = 1; cyc(); start = 0;
      chk("os_reload", 32'(out8), 32'h02);
      chk("os_rerun", {29'd0, tc8, busy8, done8}, 32'b010);
      cyc();
      chk("os_rerun_step", 32'(out8), 32'h01);

      // auto-reload down from 5
      mode = 2'b11; up_dn = 0;
      arm(8'h05);
      for (int i = 0; i < 7; i++) begin
         cyc();
         chk("ar_out", 32'(out8), 32'(e_ar[i]));
         chk("ar_tc", 32'(tc8), 32'(t_ar[i]));
      end

      // load + stop + start together: load wins, stays in RUN
      load = 1; stop = 1; start = 1; load_val8 = 8'h20; cyc();
      load = 0; stop = 0; start = 0;
      chk("prio_out", 32'(out8), 32'h20);
      chk("prio_busy", 32'(busy8), 32'd1);
      cyc();
      chk("prio_step", 32'(out8), 32'h1F);

      // reset mid-count
      rst = 1; cyc(); rst = 0;
      chk("rst2_out8", 32'(out8), 32'h7F);
      chk("rst2_out32", out32, 32'h7FFF_FFFF);
      chk("rst2_flags8", {29'd0, tc8, busy8, done8}, 32'd0);

`ifdef PRESCALER_EN
      presc = 8'd2; mode = 2'b00; up_dn = 0;
      arm(8'h10);
      cyc();
      chk("ps_c1", 32'(out8), 32'h10);
      cyc();
      chk("ps_c2", 32'(out8), 32'h10);
      cyc();
      chk("ps_c3", 32'(out8), 32'h0F);
      cyc(); cyc();
      chk("ps_c5", 32'(out8), 32'h0F);
      cyc();
      chk("ps_c6", 32'(out8), 32'h0E);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
